// File: rtl/poly_synth_voices.sv
// poly_synth_voices
//   Polyphonic voice engine. Parses a MIDI byte stream (note-on/note-off on a
//   single channel, with running status), allocates notes to VOICES
//   phase-accumulator oscillators and mixes them into one offset-binary
//   sample stream for the sigma-delta converter.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high
//   i_rx_valid     one-cycle strobe, i_rx_byte valid
//   i_rx_byte      received MIDI byte
//   i_wave_sel     0 = saw, 1 = square (sampled per voice during the scan)
//   o_audio        unsigned mixed sample (offset binary)
//   o_audio_valid  one-cycle strobe when o_audio updates
//   o_voice_active per-voice busy flags
//
// Build option
//   SYNTH_VOICE_STEAL_EN  when defined, a note-on with all voices busy steals
//                         the oldest voice; otherwise such a note-on is dropped.
module poly_synth_voices #(
    parameter int unsigned VOICES          = 4,
    parameter int unsigned AUDIO_WIDTH     = 8,
    parameter int unsigned ACC_WIDTH       = 24,
    parameter int unsigned CLK_HZ          = 25_000_000,
    parameter int unsigned CLKS_PER_SAMPLE = 512,
    parameter int unsigned MIDI_CHANNEL    = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_byte,
    input  logic                   i_wave_sel,
    output logic [AUDIO_WIDTH-1:0] o_audio,
    output logic                   o_audio_valid,
    output logic [VOICES-1:0]      o_voice_active
);

    localparam int unsigned LOG_V = $clog2(VOICES);
    localparam int unsigned MIX_W = AUDIO_WIDTH + LOG_V;
    localparam int unsigned CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;

    localparam logic [7:0] NOTE_ON_STATUS  = {4'h9, 4'(MIDI_CHANNEL)};
    localparam logic [7:0] NOTE_OFF_STATUS = {4'h8, 4'(MIDI_CHANNEL)};

    localparam logic [AUDIO_WIDTH-1:0]        SIGN_BIT = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
    localparam logic signed [AUDIO_WIDTH-1:0] SQ_POS   = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
    localparam logic signed [AUDIO_WIDTH-1:0] SQ_NEG   = -SQ_POS;

    // Phase increment for the top octave (notes 120..131), rounded.
    function automatic logic [ACC_WIDTH-1:0] calc_inc(input int unsigned k);
        real fs;
        real freq;
        real inc;
        fs   = real'(CLK_HZ) / real'(CLKS_PER_SAMPLE);
        freq = 440.0 * (2.0 ** ((real'(k) + 51.0) / 12.0));
        inc  = (2.0 ** ACC_WIDTH) * freq / fs;
        return ACC_WIDTH'(longint'(inc));
    endfunction

    function automatic logic signed [AUDIO_WIDTH-1:0] voice_sample(
        input logic [ACC_WIDTH-1:0] ph,
        input logic                 square
    );
        if (square)
            return ph[ACC_WIDTH-1] ? SQ_NEG : SQ_POS;
        return $signed(ph[ACC_WIDTH-1 -: AUDIO_WIDTH] ^ SIGN_BIT);
    endfunction

    logic [ACC_WIDTH-1:0] inc_table [12];

    for (genvar k = 0; k < 12; k++) begin : g_inc
        localparam logic [ACC_WIDTH-1:0] INC_K = calc_inc(k);
        assign inc_table[k] = INC_K;
    end

    // ---------------------------------------------------------------- parser
    typedef enum logic [1:0] {
        P_IDLE,
        P_NOTE,
        P_VEL
    } parse_t;

    parse_t     state_q, state_nx;
    logic       is_on_q, is_on_nx;
    logic [6:0] note_q, note_nx;
    logic       ev_valid;
    logic       ev_on;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= P_IDLE;
            is_on_q <= 1'b0;
            note_q  <= '0;
        end else begin
            state_q <= state_nx;
            is_on_q <= is_on_nx;
            note_q  <= note_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        is_on_nx = is_on_q;
        note_nx  = note_q;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        if (i_rx_valid) begin
            if (i_rx_byte[7]) begin
                // Real-time bytes (F8..FF) pass through without touching state.
                if (i_rx_byte < 8'hF8) begin
                    if (i_rx_byte == NOTE_ON_STATUS) begin
                        state_nx = P_NOTE;
                        is_on_nx = 1'b1;
                    end else if (i_rx_byte == NOTE_OFF_STATUS) begin
                        state_nx = P_NOTE;
                        is_on_nx = 1'b0;
                    end else begin
                        state_nx = P_IDLE;
                        is_on_nx = 1'b0;
                    end
                end
            end else begin
                case (state_q)
                    P_NOTE: begin
                        note_nx  = i_rx_byte[6:0];
                        state_nx = P_VEL;
                    end
                    P_VEL: begin
                        ev_valid = 1'b1;
                        ev_on    = is_on_q && (i_rx_byte[6:0] != 7'd0);
                        state_nx = P_NOTE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ allocation
    logic [VOICES-1:0]    active_q;
    logic [6:0]           vnote_q [VOICES];
    logic [ACC_WIDTH-1:0] inc_q   [VOICES];
    logic [ACC_WIDTH-1:0] phase_q [VOICES];
    logic [VOICES-1:0]    match_vec;
    logic [VOICES-1:0]    alloc_vec;
    logic [VOICES-1:0]    off_vec;
    logic                 found;

    logic [3:0]           note_oct;
    logic [3:0]           note_semi;
    logic [ACC_WIDTH-1:0] new_inc;

    assign note_oct  = 4'(note_q / 7'd12);
    assign note_semi = 4'(note_q % 7'd12);
    assign new_inc   = inc_table[note_semi] >> (4'd10 - note_oct);

`ifdef SYNTH_VOICE_STEAL_EN
    localparam int unsigned AGE_W = LOG_V + 2;

    logic [AGE_W-1:0]  age_q [VOICES];
    logic [AGE_W-1:0]  best_age;
    logic [VOICES-1:0] steal_vec;

    // Oldest voice wins; strict compare keeps the lowest index on a tie.
    always_comb begin
        steal_vec    = '0;
        steal_vec[0] = 1'b1;
        best_age     = age_q[0];
        for (int unsigned i = 1; i < VOICES; i++) begin
            if (age_q[i] > best_age) begin
                steal_vec    = '0;
                steal_vec[i] = 1'b1;
                best_age     = age_q[i];
            end
        end
    end

    // Every allocation ages the other busy voices; the new one restarts at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < VOICES; i++)
                age_q[i] <= '0;
        end else if (|alloc_vec) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (alloc_vec[i])
                    age_q[i] <= '0;
                else if (active_q[i] && (age_q[i] != '1))
                    age_q[i] <= age_q[i] + AGE_W'(1);
            end
        end
    end
`endif

    always_comb begin
        match_vec = '0;
        alloc_vec = '0;
        off_vec   = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < VOICES; i++)
            match_vec[i] = active_q[i] && (vnote_q[i] == note_q);
        if (ev_valid && !ev_on)
            off_vec = match_vec;
        if (ev_valid && ev_on) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (!found && match_vec[i]) begin
                    alloc_vec[i] = 1'b1;
                    found        = 1'b1;
                end
            end
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (!found && !active_q[i]) begin
                    alloc_vec[i] = 1'b1;
                    found        = 1'b1;
                end
            end
`ifdef SYNTH_VOICE_STEAL_EN
            if (!found)
                alloc_vec = steal_vec;
`endif
        end
    end

    // ------------------------------------------------------- scan and mixing
    logic [CNT_W-1:0]              cnt_q;
    logic                          scan_run_q;
    logic [VOICES-1:0]             scan_sel;
    logic signed [AUDIO_WIDTH-1:0] scan_sample;
    logic signed [MIX_W-1:0]       mix_q;
    logic [AUDIO_WIDTH-1:0]        mix_out;

    // A voice being allocated or released in its own scan slot contributes 0.
    always_comb begin
        scan_sel    = '0;
        scan_sample = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            scan_sel[i] = scan_run_q && (cnt_q == CNT_W'(i));
            if (scan_sel[i] && active_q[i] && !alloc_vec[i] && !off_vec[i])
                scan_sample = voice_sample(phase_q[i], i_wave_sel);
        end
    end

    assign mix_out = AUDIO_WIDTH'(mix_q >>> LOG_V) ^ SIGN_BIT;

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                vnote_q[i] <= '0;
                inc_q[i]   <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (alloc_vec[i]) begin
                    active_q[i] <= 1'b1;
                    vnote_q[i]  <= note_q;
                    inc_q[i]    <= new_inc;
                    phase_q[i]  <= '0;
                end else if (off_vec[i]) begin
                    active_q[i] <= 1'b0;
                    phase_q[i]  <= '0;
                end else if (scan_sel[i] && active_q[i]) begin
                    phase_q[i] <= phase_q[i] + inc_q[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            scan_run_q    <= 1'b0;
            mix_q         <= '0;
            o_audio       <= SIGN_BIT;
            o_audio_valid <= 1'b0;
        end else begin
            o_audio_valid <= 1'b0;
            if (cnt_q == CNT_W'(CLKS_PER_SAMPLE - 1)) begin
                cnt_q      <= '0;
                scan_run_q <= 1'b1;
                mix_q      <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (scan_run_q) begin
                if (cnt_q < CNT_W'(VOICES)) begin
                    mix_q <= mix_q + MIX_W'(scan_sample);
                end else if (cnt_q == CNT_W'(VOICES)) begin
                    o_audio       <= mix_out;
                    o_audio_valid <= 1'b1;
                    scan_run_q    <= 1'b0;
                end
            end
        end
    end

    assign o_voice_active = active_q;

endmodule

// File: tb/tb_poly_synth_voices.sv
// tb_poly_synth_voices
//   Directed bench for poly_synth_voices with VOICES=4, a 16-clock sample
//   period and CLK_HZ chosen so that Fs = 44 kHz (A4 period = 100 samples).
module tb_poly_synth_voices;

    localparam int unsigned VOICES = 4;
    localparam int unsigned CPS    = 16;

    logic       clock;
    logic       reset;
    logic       i_rx_valid;
    logic [7:0] i_rx_byte;
    logic       i_wave_sel;
    logic [7:0] o_audio;
    logic       o_audio_valid;
    logic [3:0] o_voice_active;

    int n_cmp;
    int n_err;

    poly_synth_voices #(
        .VOICES          (VOICES),
        .AUDIO_WIDTH     (8),
        .ACC_WIDTH       (24),
        .CLK_HZ          (704_000),
        .CLKS_PER_SAMPLE (CPS),
        .MIDI_CHANNEL    (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_rx_valid     (i_rx_valid),
        .i_rx_byte      (i_rx_byte),
        .i_wave_sel     (i_wave_sel),
        .o_audio        (o_audio),
        .o_audio_valid  (o_audio_valid),
        .o_voice_active (o_voice_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte per clock; consecutive calls give back-to-back strobes.
    task automatic put(input logic [7:0] b);
        @(negedge clock);
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        @(posedge clock);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        i_rx_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_sample(output logic [7:0] s);
        logic ok;
        ok = 1'b0;
        s  = '0;
        for (int c = 0; c < 4 * CPS; c++) begin
            @(posedge clock);
            #1;
            if (o_audio_valid) begin
                s  = o_audio;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $error("FAIL sample_timeout: observed no o_audio_valid, expected one within %0d clocks", 4 * CPS);
        end
    endtask

    logic [7:0] s;
    logic [7:0] prev;
    int         first_clk;
    int         drops;
    int         idx_first;
    int         per;

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_byte  = '0;
        i_wave_sel = 1'b0;

        // Reset state and first-sample latency.
        do_reset();
        chk("rst_audio", 32'(o_audio), 32'h80);
        chk("rst_valid", 32'(o_audio_valid), 32'h0);
        chk("rst_active", 32'(o_voice_active), 32'h0);
        first_clk = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clock);
            #1;
            if (o_audio_valid) begin
                first_clk = c;
                break;
            end
        end
        chk("first_valid_clk", 32'(first_clk), 32'(CPS + VOICES + 1));
        chk("idle_audio", 32'(o_audio), 32'h80);

        // A4 saw: first sample at phase 0 -> (-128>>>2)+128 = 0x60; 10 periods = 1000 samples.
        put(8'h90); put(8'h45); put(8'h64);
        chk("a4_active", 32'(o_voice_active), 32'h1);
        wait_sample(s);
        chk("a4_first_sample", 32'(s), 32'h60);
        prev      = s;
        drops     = 0;
        idx_first = 0;
        per       = 0;
        for (int k = 1; k <= 1300; k++) begin
            wait_sample(s);
            if (s < prev) begin
                drops++;
                if (drops == 1) idx_first = k;
                if (drops == 11) begin
                    per = k - idx_first;
                    break;
                end
            end
            prev = s;
        end
        chk("a4_10_periods", (per >= 999 && per <= 1001) ? 32'd1000 : 32'(per), 32'd1000);

        // Running status and velocity-0 release.
        do_reset();
        put(8'h90); put(8'h3C); put(8'h40);
        chk("rs_first_on", 32'(o_voice_active), 32'h1);
        put(8'h40); put(8'h40);
        chk("rs_second_on", 32'(o_voice_active), 32'h3);
        put(8'h3C); put(8'h00);
        chk("rs_vel0_off", 32'(o_voice_active), 32'h2);
        put(8'h40); put(8'h7F);
        chk("retrigger_same_note", 32'(o_voice_active), 32'h2);
        put(8'h80); put(8'h40); put(8'h00);
        chk("note_off", 32'(o_voice_active), 32'h0);

        // Wrong channel, real-time, stray data, other status.
        put(8'h91); put(8'h3C); put(8'h40);
        chk("wrong_channel", 32'(o_voice_active), 32'h0);
        put(8'hF8);
        chk("realtime_idle", 32'(o_voice_active), 32'h0);
        put(8'h30);
        chk("stray_data", 32'(o_voice_active), 32'h0);
        put(8'h90); put(8'hF8); put(8'h3C); put(8'h40);
        chk("realtime_inside_msg", 32'(o_voice_active), 32'h1);
        put(8'hB0); put(8'h3D); put(8'h40);
        chk("other_status_clears", 32'(o_voice_active), 32'h1);

        // Reset mid-message: the pending note byte is forgotten.
        put(8'h90); put(8'h3C);
        do_reset();
        put(8'h40);
        chk("reset_mid_msg", 32'(o_voice_active), 32'h0);

        // Five note-ons on four voices.
        put(8'h90); put(8'h30); put(8'h40); put(8'h31); put(8'h40);
        put(8'h32); put(8'h40); put(8'h33); put(8'h40);
        chk("four_on", 32'(o_voice_active), 32'hF);
        put(8'h34); put(8'h40);
        chk("fifth_on", 32'(o_voice_active), 32'hF);
        put(8'h80); put(8'h30); put(8'h00);
`ifdef SYNTH_VOICE_STEAL_EN
        chk("off_first_note", 32'(o_voice_active), 32'hF);
`else
        chk("off_first_note", 32'(o_voice_active), 32'hE);
`endif
        put(8'h34); put(8'h00);
        chk("off_fifth_note", 32'(o_voice_active), 32'hE);

        // Square, notes 124..127 started together; sample k uses phase k*inc.
        do_reset();
        i_wave_sel = 1'b1;
        wait_sample(s);
        chk("sq_idle", 32'(s), 32'h80);
        put(8'h90); put(8'h7C); put(8'h7F); put(8'h7D); put(8'h7F);
        put(8'h7E); put(8'h7F); put(8'h7F); put(8'h7F);
        chk("sq_active", 32'(o_voice_active), 32'hF);
        wait_sample(s);
        chk("sq_s0_max", 32'(s), 32'hFF);
        wait_sample(s);
        chk("sq_s1_max", 32'(s), 32'hFF);
        wait_sample(s);
        chk("sq_s2_mixed", 32'(s), 32'h40);
        wait_sample(s);
        chk("sq_s3_min", 32'(s), 32'h01);
        put(8'h80); put(8'h7C); put(8'h00); put(8'h7D); put(8'h00);
        put(8'h7E); put(8'h00); put(8'h7F); put(8'h00);
        chk("sq_all_off", 32'(o_voice_active), 32'h0);
        wait_sample(s);
        chk("sq_silent", 32'(s), 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
